// File: rtl/clk_div_sel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_sel_pkg
// Description : Shared state encoding and sizing helper for clk_div_sel.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_sel_pkg;

    typedef enum logic [1:0] {
        RUN           = 2'd0,
        WAIT_OLD_LOW  = 2'd1,
        WAIT_NEW_LOW  = 2'd2,
        WAIT_NEW_RISE = 2'd3
    } state_t;

    function automatic int sel_width(input int num_src);
        return (num_src <= 2) ? 1 : $clog2(num_src);
    endfunction

endpackage : clk_div_sel_pkg
`default_nettype wire

// File: rtl/clk_div_sel.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_sel
// Description : Glitch-free run-time selector/gate for clk_in-registered
//               power-of-two divided clocks, with a clk_in-domain rise strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_sel
    import clk_div_sel_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = sel_width(NUM_SRC),
    parameter int RST_SEL = 0
) (
    input  logic               clk_in,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] div_clk_i,
    input  logic               clk_en_i,
    input  logic               sel_req_i,
    input  logic [SEL_W-1:0]   sel_i,
    output logic               sel_ack_o,
    output logic               sel_err_o,
    output logic               busy_o,
    output logic [SEL_W-1:0]   cur_sel_o,
    output logic               clk_out,
    output logic               rise_stb_o
);

    localparam logic [SEL_W-1:0] c_RST_SEL = SEL_W'(RST_SEL);

    state_t             r_state;
    logic [SEL_W-1:0]   r_cur_sel;
    logic [SEL_W-1:0]   r_new_sel;
    logic               r_en_q;
    logic               r_clk_out;
    logic               r_rise_stb;
    logic               r_ack;
    logic               r_err;
    logic               r_busy;

    logic               w_cur_src;
    logic               w_new_src;
    logic               w_en_nxt;
    logic               w_clk_out_nxt;
    logic               w_req_valid;

    // Explicit compare-mux keeps the index width independent of NUM_SRC.
    always_comb begin
        w_cur_src = 1'b0;
        w_new_src = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_cur_sel == SEL_W'(i)) w_cur_src = div_clk_i[i];
            if (r_new_sel == SEL_W'(i)) w_new_src = div_clk_i[i];
        end
    end

    // The gate only moves while the running source is low, so no high phase is cut.
    assign w_en_nxt    = (r_state == RUN && !w_cur_src) ? clk_en_i : r_en_q;
    assign w_req_valid = (32'(sel_i) < NUM_SRC);

    always_comb begin
        w_clk_out_nxt = 1'b0;
        case (r_state)
            RUN:           w_clk_out_nxt = w_cur_src & w_en_nxt;
            WAIT_OLD_LOW:  w_clk_out_nxt = w_cur_src & r_en_q;
            WAIT_NEW_LOW:  w_clk_out_nxt = 1'b0;
            WAIT_NEW_RISE: w_clk_out_nxt = w_new_src & r_en_q;
            default:       w_clk_out_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= RUN;
            r_cur_sel  <= c_RST_SEL;
            r_new_sel  <= c_RST_SEL;
            r_en_q     <= 1'b0;
            r_clk_out  <= 1'b0;
            r_rise_stb <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_en_q     <= w_en_nxt;
            r_clk_out  <= w_clk_out_nxt;
            r_rise_stb <= w_clk_out_nxt & ~r_clk_out;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                RUN: begin
                    if (sel_req_i) begin
                        if (!w_req_valid) begin
                            r_err <= 1'b1;
                        end else if (sel_i == r_cur_sel) begin
                            r_ack <= 1'b1;
                        end else begin
                            r_new_sel <= sel_i;
                            r_busy    <= 1'b1;
                            r_state   <= w_cur_src ? WAIT_OLD_LOW : WAIT_NEW_LOW;
                        end
                    end
                end
                WAIT_OLD_LOW: begin
                    if (!w_cur_src) r_state <= WAIT_NEW_LOW;
                end
                WAIT_NEW_LOW: begin
                    if (!w_new_src) r_state <= WAIT_NEW_RISE;
                end
                WAIT_NEW_RISE: begin
                    if (w_new_src) begin
                        r_cur_sel <= r_new_sel;
                        r_ack     <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= RUN;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign sel_ack_o  = r_ack;
    assign sel_err_o  = r_err;
    assign busy_o     = r_busy;
    assign cur_sel_o  = r_cur_sel;
    assign clk_out    = r_clk_out;
    assign rise_stb_o = r_rise_stb;

endmodule : clk_div_sel
`default_nettype wire

// File: tb/tb_clk_div_sel.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_sel
// Description : Directed self-checking bench for clk_div_sel with div2/4/8/16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_sel;

    localparam int NUM_SRC = 4;
    localparam int SEL_W   = 3;

    logic               clk_in = 1'b0;
    logic               reset_n;
    logic               div_rst_n;
    logic [NUM_SRC-1:0] div_clk;
    logic               clk_en;
    logic               sel_req;
    logic [SEL_W-1:0]   sel;
    logic               sel_ack;
    logic               sel_err;
    logic               busy;
    logic [SEL_W-1:0]   cur_sel;
    logic               clk_out;
    logic               rise_stb;

    int n_checks = 0;
    int n_fail   = 0;
    int ack_cnt  = 0;

    always #5 clk_in = ~clk_in;

    // Source i is a free-running clk_in-registered divide-by-2^(i+1).
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_div
        localparam logic [NUM_SRC-1:0] c_ONE = 1;
        logic [NUM_SRC-1:0] r_cnt;
        always_ff @(posedge clk_in or negedge div_rst_n) begin
            if (!div_rst_n) r_cnt <= '0;
            else            r_cnt <= r_cnt + c_ONE;
        end
        assign div_clk[gi] = r_cnt[gi];
    end

    clk_div_sel #(.NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .RST_SEL(0)) dut (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .div_clk_i  (div_clk),
        .clk_en_i   (clk_en),
        .sel_req_i  (sel_req),
        .sel_i      (sel),
        .sel_ack_o  (sel_ack),
        .sel_err_o  (sel_err),
        .busy_o     (busy),
        .cur_sel_o  (cur_sel),
        .clk_out    (clk_out),
        .rise_stb_o (rise_stb)
    );

    task automatic wait_rise(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_in);
            if (sel_ack) ack_cnt++;
            if (rise_stb) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Length of the clk_out run at 'level' starting at the current sample.
    task automatic count_run(input bit level, output int len);
        len = 0;
        while (clk_out === level && len < 40) begin
            len++;
            @(negedge clk_in);
            if (sel_ack) ack_cnt++;
        end
    endtask

    task automatic do_switch(input logic [SEL_W-1:0] s, output bit ok);
        sel_req = 1'b1;
        sel     = s;
        @(negedge clk_in);
        sel_req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (sel_ack) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; div_rst_n = 1'b0; clk_en = 1'b1; sel_req = 1'b0; sel = '0;
        repeat (3) @(negedge clk_in);
        n_checks++; if (clk_out !== 1'b0) begin n_fail++; $display("FAIL reset_clk_out: got %b want 0", clk_out); end
        n_checks++; if ({sel_ack, sel_err, busy, rise_stb} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {sel_ack, sel_err, busy, rise_stb}); end
        n_checks++; if (cur_sel !== 3'd0) begin n_fail++; $display("FAIL reset_cur_sel: got %0d want 0", cur_sel); end
        reset_n = 1'b1; div_rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_in);
            n_checks++; if (clk_out !== (k % 2 == 0)) begin n_fail++; $display("FAIL div2_wave[%0d]: got %b want %b", k, clk_out, (k % 2 == 0)); end
            n_checks++; if (rise_stb !== (k % 2 == 0)) begin n_fail++; $display("FAIL div2_stb[%0d]: got %b want %b", k, rise_stb, (k % 2 == 0)); end
        end
    endtask

    task automatic test_switch;
        bit ok;
        int lat, bad_hi, errs, hi, lo;
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk_in);
            ok = div_clk[0];
        end
        sel_req = 1'b1; sel = 3'd2;
        @(negedge clk_in);
        sel_req = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sw_busy: got %b want 1", busy); end
        n_checks++; if (clk_out !== 1'b1) begin n_fail++; $display("FAIL sw_old_high: got %b want 1", clk_out); end
        @(negedge clk_in);
        n_checks++; if (clk_out !== 1'b0) begin n_fail++; $display("FAIL sw_old_low: got %b want 0", clk_out); end
        sel_req = 1'b1; sel = 3'd3;
        lat = 2; bad_hi = 0; errs = 0; ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_in);
            sel_req = 1'b0;
            lat++;
            if (sel_err) errs++;
            if (sel_ack) begin ok = 1'b1; break; end
            if (clk_out) bad_hi++;
        end
        n_checks++; if (!ok || lat - 1 > 10) begin n_fail++; $display("FAIL sw_latency: got %0d cycles (ack %b) want <=10", lat - 1, ok); end
        n_checks++; if (bad_hi !== 0) begin n_fail++; $display("FAIL sw_gap_high: got %0d high cycles want 0", bad_hi); end
        n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL sw_busy_err: got %0d want 0", errs); end
        n_checks++; if (cur_sel !== 3'd2 || busy !== 1'b0) begin n_fail++; $display("FAIL sw_done: got sel %0d busy %b want sel 2 busy 0", cur_sel, busy); end
        n_checks++; if (clk_out !== 1'b1 || rise_stb !== 1'b1) begin n_fail++; $display("FAIL sw_first_rise: got clk %b stb %b want 1 1", clk_out, rise_stb); end
        ack_cnt = 0;
        count_run(1'b1, hi);
        count_run(1'b0, lo);
        n_checks++; if (hi !== 4 || lo !== 4) begin n_fail++; $display("FAIL sw_div8_phase: got hi %0d lo %0d want 4 4", hi, lo); end
        count_run(1'b1, hi);
        n_checks++; if (hi !== 4) begin n_fail++; $display("FAIL sw_div8_hi2: got %0d want 4", hi); end
        n_checks++; if (ack_cnt !== 0 || cur_sel !== 3'd2) begin n_fail++; $display("FAIL sw_single_ack: got extra acks %0d sel %0d want 0 2", ack_cnt, cur_sel); end
    endtask

    task automatic test_noop_err;
        bit ok;
        int hi, lo;
        wait_rise(ok);
        sel_req = 1'b1; sel = 3'd2;
        @(negedge clk_in);
        sel_req = 1'b0;
        n_checks++; if (sel_ack !== 1'b1 || sel_err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL noop_ack: got ack %b err %b busy %b want 1 0 0", sel_ack, sel_err, busy); end
        count_run(1'b1, hi);
        count_run(1'b0, lo);
        n_checks++; if (!ok || hi !== 3 || lo !== 4) begin n_fail++; $display("FAIL noop_wave: got hi %0d lo %0d want 3 4", hi, lo); end
        sel_req = 1'b1; sel = 3'd5;
        @(negedge clk_in);
        sel_req = 1'b0;
        n_checks++; if (sel_err !== 1'b1 || sel_ack !== 1'b0 || busy !== 1'b0 || cur_sel !== 3'd2) begin n_fail++; $display("FAIL err_pulse: got err %b ack %b busy %b sel %0d want 1 0 0 2", sel_err, sel_ack, busy, cur_sel); end
        @(negedge clk_in);
        n_checks++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL err_single: got %b want 0", sel_err); end
        wait_rise(ok);
        count_run(1'b1, hi);
        n_checks++; if (!ok || hi !== 4) begin n_fail++; $display("FAIL err_wave: got hi %0d want 4", hi); end
    endtask

    task automatic test_gate;
        bit ok;
        int hi, lo, hi_cnt;
        do_switch(3'd3, ok);
        n_checks++; if (!ok || cur_sel !== 3'd3) begin n_fail++; $display("FAIL gate_switch: got ack %b sel %0d want 1 3", ok, cur_sel); end
        wait_rise(ok);
        @(negedge clk_in);
        clk_en = 1'b0;
        count_run(1'b1, hi);
        n_checks++; if (!ok || hi !== 7) begin n_fail++; $display("FAIL gate_off_finish: got %0d more high want 7", hi); end
        hi_cnt = 0;
        repeat (40) begin
            @(negedge clk_in);
            if (clk_out) hi_cnt++;
        end
        n_checks++; if (hi_cnt !== 0) begin n_fail++; $display("FAIL gate_off_quiet: got %0d high want 0", hi_cnt); end
        clk_en = 1'b1;
        wait_rise(ok);
        count_run(1'b1, hi);
        count_run(1'b0, lo);
        n_checks++; if (!ok || hi !== 8 || lo !== 8) begin n_fail++; $display("FAIL gate_on_phase: got hi %0d lo %0d want 8 8", hi, lo); end
    endtask

    task automatic test_reset_mid_switch;
        bit ok;
        int hi, lo;
        do_switch(3'd1, ok);
        n_checks++; if (!ok || cur_sel !== 3'd1) begin n_fail++; $display("FAIL rst_pre_switch: got ack %b sel %0d want 1 1", ok, cur_sel); end
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk_in);
            ok = (div_clk == 4'b1000);
        end
        sel_req = 1'b1; sel = 3'd3;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk_in);
            sel_req = 1'b0;
            ok = (div_clk == 4'b0100);
        end
        n_checks++; if (!ok || busy !== 1'b1 || clk_out !== 1'b0) begin n_fail++; $display("FAIL rst_in_wait: got found %b busy %b clk %b want 1 1 0", ok, busy, clk_out); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (clk_out !== 1'b0 || busy !== 1'b0 || cur_sel !== 3'd0 || sel_ack !== 1'b0) begin n_fail++; $display("FAIL rst_async: got clk %b busy %b sel %0d ack %b want 0 0 0 0", clk_out, busy, cur_sel, sel_ack); end
        repeat (3) @(negedge clk_in);
        reset_n = 1'b1;
        ack_cnt = 0;
        repeat (30) begin
            @(negedge clk_in);
            if (sel_ack) ack_cnt++;
        end
        n_checks++; if (ack_cnt !== 0 || cur_sel !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_no_ack: got acks %0d sel %0d busy %b want 0 0 0", ack_cnt, cur_sel, busy); end
        wait_rise(ok);
        count_run(1'b1, hi);
        count_run(1'b0, lo);
        n_checks++; if (!ok || hi !== 1 || lo !== 1) begin n_fail++; $display("FAIL rst_div2_wave: got hi %0d lo %0d want 1 1", hi, lo); end
    endtask

    initial begin
        test_reset;
        test_switch;
        test_noop_err;
        test_gate;
        test_reset_mid_switch;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_clk_div_sel
`default_nettype wire

// File: doc/clk_div_sel.md
Name: clk_div_sel

Overview:
Glitch-free run-time selector that sits directly downstream of a bank of power-of-two clock dividers. All of those dividers are clocked by clk_in and have registered outputs. The block picks one divided clock and re-registers it on clk_in to drive a divided clock tree. It sequences ratio changes so clk_out never shows a truncated high or low phase. It also provides a safe clock-gate and a clk_in-domain rise strobe for logic that must act on divided-clock edges.

Parameters:
NUM_SRC, 4, number of divided-clock inputs (2..16)
SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_SRC
RST_SEL, 0, source index selected out of reset (< NUM_SRC)

Ports:
clk_in  input  1  source clock; all logic in this domain
reset_n  input  1  asynchronous, active-low reset
div_clk_i  input  NUM_SRC  divided clocks; each is a clk_in-registered divider output
clk_en_i  input  1  clock gate request; 1 = clk_out toggles
sel_req_i  input  1  one-cycle pulse requesting a switch to sel_i
sel_i  input  SEL_W  requested source index, valid with sel_req_i
sel_ack_o  output  1  one-cycle pulse: switch complete, or no-op request accepted
sel_err_o  output  1  one-cycle pulse: request rejected (sel_i >= NUM_SRC)
busy_o  output  1  high while a switch is in progress (state != RUN)
cur_sel_o  output  SEL_W  currently driving source index
clk_out  output  1  registered selected/gated divided clock
rise_stb_o  output  1  high for exactly the first clk_in cycle of each clk_out high phase

Behaviour:
- Reset (async, reset_n=0): state=RUN, cur_sel=RST_SEL, new_sel=RST_SEL, en_q=0, clk_out=0. rise_stb_o, sel_ack_o, sel_err_o and busy_o are all 0. Reset asserted mid-switch aborts the switch immediately; no ack is issued.
- All outputs are registered on posedge clk_in.
- Gate:
  - en_q <= clk_en_i only in cycles where div_clk_i[cur_sel]==0 and state==RUN. Otherwise en_q holds.
  - Consequence: gating on or off never truncates a high phase.
- State RUN:
  - clk_out <= div_clk_i[cur_sel] & en_q_next. This gives 1 clk_in cycle latency from source to output.
  - On sel_req_i with sel_i >= NUM_SRC: sel_err_o pulses the next cycle; no other change.
  - On sel_req_i with sel_i == cur_sel: sel_ack_o pulses the next cycle; no other change.
  - On sel_req_i with any other valid sel_i: new_sel <= sel_i and busy_o <= 1. Go to WAIT_NEW_LOW if div_clk_i[cur_sel]==0, otherwise go to WAIT_OLD_LOW.
- State WAIT_OLD_LOW: clk_out keeps following the old source (& en_q). When div_clk_i[cur_sel]==0: clk_out <= 0, go to WAIT_NEW_LOW.
- State WAIT_NEW_LOW: clk_out held 0. When div_clk_i[new_sel]==0, go to WAIT_NEW_RISE.
- State WAIT_NEW_RISE: clk_out held 0. When div_clk_i[new_sel]==1:
  - cur_sel <= new_sel, clk_out <= en_q, state <= RUN;
  - sel_ack_o pulses in that same registered cycle; busy_o <= 0.
- Request and gate handling while busy:
  - sel_req_i while busy_o=1 is ignored: no ack, no err. The requester must wait for sel_ack_o.
  - clk_en_i changes while busy are picked up in RUN once the source is low.
- Guarantees:
  - Every clk_out high and low phase equals a full phase of a source.
  - The low phase during a switch is ≥ the new source's low phase.
  - Switch latency ≤ old_high + new_period + 1 clk_in cycles.
- rise_stb_o <= (clk_out_next==1 && clk_out==0).
- cur_sel_o reflects the registered cur_sel. It changes in the same cycle as sel_ack_o.

Decomposition:
- Shared package clk_div_sel_pkg holds:
  - the state encoding: RUN=2'd0, WAIT_OLD_LOW=2'd1, WAIT_NEW_LOW=2'd2, WAIT_NEW_RISE=2'd3;
  - a function returning SEL_W for a given NUM_SRC.
- No sub-module: a single FSM plus the mux/output register.
- The testbench instantiates NUM_SRC generic power-of-two divider instances as the sources.

Test Plan:
- Reset, NUM_SRC=4 with sources div2/4/8/16, clk_en_i=1 → clk_out=0 during reset. After release, clk_out is the div2 waveform with period 2 clk_in cycles; rise_stb_o fires every 2 cycles.
- Switch 0→2 (div8) requested while the div2 source is high → clk_out goes low after ≤1 cycle. No high pulse < 4 cycles. sel_ack_o arrives within 10 cycles; afterwards clk_out period is 8 and cur_sel_o=2.
- sel_req_i with sel_i=2 while cur_sel=2 → sel_ack_o the next cycle, clk_out waveform undisturbed. sel_i=5 with SEL_W=3, NUM_SRC=4 → sel_err_o the next cycle, no change.
- Second request during busy (3 during a 0→2 switch) → ignored; a single ack is issued for 2 only.
- Deassert clk_en_i mid-high-phase on div16 → the current 8-cycle high completes, then clk_out stays 0. Reassert → the next high phase is a full 8 cycles.
- Assert reset_n=0 while in WAIT_NEW_RISE → clk_out=0, busy_o=0, cur_sel_o=RST_SEL immediately; no sel_ack_o after release.
